// File: rtl/add_share_arbiter.sv
// One shared WIDTH-bit adder serving NREQ requesters through a round-robin
// valid/ready arbiter, with a single registered result stage and an op counter.
module add_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [CNTW-1:0]       op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic              hit_s;
    logic              can_accept_s;
    logic [IDW-1:0]    win_s;
    logic [NREQ-1:0]   grant_s;
    logic [WIDTH-1:0]  op_a_s;
    logic [WIDTH-1:0]  op_b_s;

    // Round-robin search: first valid index above the pointer, otherwise wrap to the lowest valid index.
    always_comb begin
        hit_s = 1'b0;
        win_s = {IDW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (!hit_s && req_valid[i] && (IDW'(i) > ptr_q)) begin
                hit_s = 1'b1;
                win_s = IDW'(i);
            end else begin
                hit_s = hit_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!hit_s && req_valid[i]) begin
                hit_s = 1'b1;
                win_s = IDW'(i);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // One-hot grant, suppressed during reset and while a held result is not being consumed.
    always_comb begin
        can_accept_s = (state_q == EMPTY) || rsp_ready;
        if (reset && can_accept_s && hit_s) begin
            grant_s = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
        end else begin
            grant_s = {NREQ{1'b0}};
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        op_a_s = {WIDTH{1'b0}};
        op_b_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_s) begin
                op_a_s = req_a[i*WIDTH +: WIDTH];
                op_b_s = req_b[i*WIDTH +: WIDTH];
            end else begin
                op_a_s = op_a_s;
            end
        end
    end

    // Result-stage next state: load on transfer, drain on consume, otherwise hold.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (|grant_s) begin
            state_d = FULL;
            data_d  = op_a_s + op_b_s;
            id_d    = win_s;
            ptr_d   = win_s;
            if (&cnt_q) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // State registers; the pointer resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= EMPTY;
            data_q  <= {WIDTH{1'b0}};
            id_q    <= {IDW{1'b0}};
            ptr_q   <= IDW'(NREQ - 1);
            cnt_q   <= {CNTW{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = grant_s;
    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: directed vector table, saturation sequence and
// constrained-random traffic checked against an arithmetic round-robin model.
module tb_add_share_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 4;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_data;
    logic [CW-1:0]   op_count;

    add_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW), .CNTW(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .op_count  (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] drv_a [N];
    logic [W-1:0] drv_b [N];

    // reference model state
    bit           m_valid = 1'b0;
    int           m_id    = 0;
    logic [W-1:0] m_data  = '0;
    int           m_cnt   = 0;
    int           m_ptr   = N - 1;
    int           last_grant = -1;
    logic [N-1:0] last_rdy;

    typedef struct {
        logic       rstn;
        logic [3:0] vld;
        logic       rdy;
        logic [31:0] a;
        logic [31:0] b;
        logic       sp;
        logic [3:0] e_rdy;
        logic       e_v;
        logic [1:0] e_id;
        logic [31:0] e_d;
        logic [3:0] e_c;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input logic rstn, input logic [N-1:0] v, input logic rdy);
        reset     = rstn;
        req_valid = v;
        rsp_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = drv_a[i];
            req_b[i*W +: W] = drv_b[i];
        end
    endtask

    // One clock: check grant mid-cycle, advance model at the edge, check outputs after it.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clock);
        g = -1;
        if (reset && (!m_valid || rsp_ready)) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        last_rdy   = req_ready;
        last_grant = g;
        check("req_ready", req_ready, exp_rdy);
        @(posedge clock);
        if (!reset) begin
            m_valid = 1'b0; m_id = 0; m_data = '0; m_cnt = 0; m_ptr = N - 1;
        end else if (g >= 0) begin
            m_data  = drv_a[g] + drv_b[g];
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = g;
            if (m_cnt < (2**CW) - 1) m_cnt++;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("rsp_valid", rsp_valid, m_valid);
        check("rsp_id", rsp_id, m_id);
        check("rsp_data", rsp_data, m_data);
        check("op_count", op_count, m_cnt);
    endtask

    initial begin
        reset = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        for (int i = 0; i < N; i++) begin drv_a[i] = '0; drv_b[i] = '0; end

        //            rstn  vld   rdy   a             b          sp    e_rdy e_v   e_id  e_d           e_c
        tbl[0]  = '{1'b0, 4'hF, 1'b1, 32'h0,        32'h0,     1'b0, 4'h0, 1'b0, 2'd0, 32'h0,        4'd0};
        tbl[1]  = '{1'b0, 4'hF, 1'b1, 32'h0,        32'h0,     1'b0, 4'h0, 1'b0, 2'd0, 32'h0,        4'd0};
        tbl[2]  = '{1'b1, 4'h4, 1'b1, 32'h5,        32'h7,     1'b0, 4'h4, 1'b1, 2'd2, 32'hC,        4'd1};
        tbl[3]  = '{1'b0, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h0, 1'b0, 2'd0, 32'h0,        4'd0};
        tbl[4]  = '{1'b1, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h1, 1'b1, 2'd0, 32'h11,       4'd1};
        tbl[5]  = '{1'b1, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h2, 1'b1, 2'd1, 32'h10011,    4'd2};
        tbl[6]  = '{1'b1, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h4, 1'b1, 2'd2, 32'h20011,    4'd3};
        tbl[7]  = '{1'b1, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h8, 1'b1, 2'd3, 32'h30011,    4'd4};
        tbl[8]  = '{1'b1, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h1, 1'b1, 2'd0, 32'h11,       4'd5};
        tbl[9]  = '{1'b1, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h2, 1'b1, 2'd1, 32'h10011,    4'd6};
        tbl[10] = '{1'b0, 4'hF, 1'b1, 32'h10,       32'h1,     1'b1, 4'h0, 1'b0, 2'd0, 32'h0,        4'd0};
        tbl[11] = '{1'b1, 4'h1, 1'b1, 32'hFFFFFFFF, 32'h2,     1'b0, 4'h1, 1'b1, 2'd0, 32'h1,        4'd1};
        tbl[12] = '{1'b1, 4'h3, 1'b0, 32'h100,      32'h1,     1'b1, 4'h0, 1'b1, 2'd0, 32'h1,        4'd1};
        tbl[13] = '{1'b1, 4'h3, 1'b0, 32'h100,      32'h1,     1'b1, 4'h0, 1'b1, 2'd0, 32'h1,        4'd1};
        tbl[14] = '{1'b1, 4'h3, 1'b0, 32'h100,      32'h1,     1'b1, 4'h0, 1'b1, 2'd0, 32'h1,        4'd1};
        tbl[15] = '{1'b1, 4'h3, 1'b1, 32'h100,      32'h1,     1'b1, 4'h2, 1'b1, 2'd1, 32'h10101,    4'd2};
        tbl[16] = '{1'b1, 4'h1, 1'b0, 32'h100,      32'h1,     1'b1, 4'h0, 1'b1, 2'd1, 32'h10101,    4'd2};
        tbl[17] = '{1'b1, 4'h1, 1'b1, 32'h100,      32'h1,     1'b1, 4'h1, 1'b1, 2'd0, 32'h101,      4'd3};
        tbl[18] = '{1'b1, 4'h0, 1'b1, 32'h100,      32'h1,     1'b1, 4'h0, 1'b0, 2'd0, 32'h101,      4'd3};

        for (int t = 0; t < 19; t++) begin
            for (int i = 0; i < N; i++) begin
                drv_a[i] = tbl[t].a + (tbl[t].sp ? (32'(i) << 16) : 32'h0);
                drv_b[i] = tbl[t].b;
            end
            apply(tbl[t].rstn, tbl[t].vld, tbl[t].rdy);
            cycle();
            check($sformatf("tbl%0d_ready", t), last_rdy, tbl[t].e_rdy);
            check($sformatf("tbl%0d_valid", t), rsp_valid, tbl[t].e_v);
            check($sformatf("tbl%0d_id", t), rsp_id, tbl[t].e_id);
            check($sformatf("tbl%0d_data", t), rsp_data, tbl[t].e_d);
            check($sformatf("tbl%0d_count", t), op_count, tbl[t].e_c);
        end

        // saturation: a lone requester 3 issues 18 back-to-back ops after reset
        apply(1'b0, 4'h8, 1'b1);
        cycle();
        for (int k = 1; k <= 18; k++) begin
            drv_a[3] = $urandom;
            drv_b[3] = $urandom;
            apply(1'b1, 4'h8, 1'b1);
            cycle();
            check("sat_ready", last_rdy, 4'h8);
            check("sat_id", rsp_id, 2'd3);
            check("sat_count", op_count, (k < 15) ? k : 15);
        end
        check("sat_final", op_count, 4'hF);

        // random traffic; a pending request keeps its operands until granted
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] v;
            v = req_valid;
            for (int i = 0; i < N; i++) begin
                if (!v[i] || last_grant == i || !reset) begin
                    v[i]     = ($urandom_range(0, 2) != 0);
                    drv_a[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : $urandom;
                    drv_b[i] = $urandom;
                end
            end
            apply(($urandom_range(0, 39) != 0), v, ($urandom_range(0, 3) != 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
